regfile_scoreboard: RTL and testbench

Parametrised general-purpose register file for the CPU datapath: DEPTH entries of WIDTH bits, one write port with byte enables, NREAD combinational read ports with optional write-through bypass, and a hardwired zero register. It also carries a per-entry pending scoreboard (set on issue, cleared on writeback) so the hazard logic can stall on in-flight destinations. It replaces fixed-width 32-bit storage in the regfile.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/register_param.sv | 17 +
 rtl/regfile_scoreboard.sv | 92 +++++++++
 tb/tb_regfile_scoreboard.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and the byte-lane merge used by both the regfile write path
// and the same-cycle bypass path.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_NREAD = 2;
  localparam int ZERO_ADDR     = 0;

  // One byte lane of a byte-enable merge: enabled lanes take the new byte.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/register_param.sv
// W-bit storage register with load enable and asynchronous active-high clear.
module register_param #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with byte-enable writeback, combinational read ports with
// optional write-through bypass, a hardwired zero register and a pending scoreboard.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NREAD    = DEFAULT_NREAD,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [WIDTH/8-1:0]     wbe,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic [NREAD-1:0]       rd_pending,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_addr,
  output logic [DEPTH-1:0]       pending_vec
);

  // No valid/ready handshake: one write and one issue are accepted every cycle,
  // and reads are purely combinational with no backpressure.
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pending_q, pending_d;
  logic             waddr_ok, issue_ok, wr_en;
  logic [WIDTH-1:0] wr_old, wr_merged;

  // An address is usable when it is inside the array and not the zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (32'(a) == ZERO_ADDR));
  endfunction

  assign waddr_ok = addr_ok(waddr);
  assign issue_ok = addr_ok(issue_addr);
  assign wr_en    = we && waddr_ok && !clr;
  assign wr_old   = waddr_ok ? mem[waddr] : '0;

  // One merged word serves both the storage update and the bypass.
  always_comb begin
    wr_merged = '0;
    for (int k = 0; k < NB; k++)
      wr_merged[8*k +: 8] = merge_byte(wr_old[8*k +: 8], wdata[8*k +: 8], wbe[k]);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    register_param #(.W(WIDTH)) u_entry (
      .clk (clk),
      .clr (clr),
      .en  (wr_en && (waddr == AW'(i))),
      .d   (wr_merged),
      .q   (mem[i])
    );
  end

  // Issue beats writeback on the same entry: the new producer supersedes the retiring one.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_valid && issue_ok && (issue_addr == AW'(i)))
        pending_d[i] = 1'b1;
      else if (wr_en && (waddr == AW'(i)))
        pending_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending_vec = pending_q;

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [AW-1:0] ra;
    logic          ra_ok, hit;

    assign ra    = raddr[p*AW +: AW];
    assign ra_ok = addr_ok(ra) && !clr;
    assign hit   = (BYPASS != 0) && wr_en && (ra == waddr);

    assign rdata[p*WIDTH +: WIDTH] = !ra_ok ? '0 : (hit ? wr_merged : mem[ra]);
    // Pending is never bypassed: a same-cycle writeback still reads as pending.
    assign rd_pending[p] = ra_ok && pending_q[ra];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: default instance plus BYPASS=0 and DEPTH=24 variants
// sharing one stimulus stream.
module tb_regfile_scoreboard;

  localparam int W  = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            clr;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [W-1:0]    wdata;
  logic [3:0]      wbe;
  logic [2*AW-1:0] raddr;
  logic            issue_valid;
  logic [AW-1:0]   issue_addr;

  logic [2*W-1:0]  rdata_a, rdata_b, rdata_c;
  logic [1:0]      rp_a, rp_b, rp_c;
  logic [31:0]     pv_a, pv_b;
  logic [23:0]     pv_c;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v, got_v;
  logic [W-1:0] vals[8];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut_a (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr(raddr), .rdata(rdata_a), .rd_pending(rp_a),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .pending_vec(pv_a));

  regfile_scoreboard #(.BYPASS(0)) dut_b (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr(raddr), .rdata(rdata_b), .rd_pending(rp_b),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .pending_vec(pv_b));

  regfile_scoreboard #(.DEPTH(24)) dut_c (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr(raddr), .rdata(rdata_c), .rd_pending(rp_c),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .pending_vec(pv_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
    raddr = {5'd5, 5'd0}; issue_valid = 1'b0; issue_addr = '0;
    tick();
    exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0);
    got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL reset_rdata got=%h exp=%h", got_v, exp_v); end
    got_v = pv_a; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL reset_pv got=%h exp=%h", got_v, exp_v); end
    got_v = W'(rp_a); exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL reset_rdpend got=%h exp=%h", got_v, exp_v); end
    got_v = W'(pv_c); exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL reset_pv_d24 got=%h exp=%h", got_v, exp_v); end
    clr = 1'b0;
  endtask

  task automatic test_write_read;
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wbe = 4'hF; raddr = '0;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back('0); exp_q.push_back(32'hDEADBEEF);
    tick();
    we = 1'b0; raddr = {5'd0, 5'd5};
    #1;
    got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL wr_rd_port0 got=%h exp=%h", got_v, exp_v); end
    got_v = rdata_a[63:32]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL rd_zero_port1 got=%h exp=%h", got_v, exp_v); end
    got_v = rdata_b[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL wr_rd_nobypass got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_byte_merge;
    we = 1'b1; waddr = 5'd5; wdata = 32'hAABBCCDD; wbe = 4'b0101; raddr = {5'd5, 5'd5};
    exp_q.push_back(32'hDEBBBEDD); exp_q.push_back(32'hDEBBBEDD); exp_q.push_back(32'hDEADBEEF);
    #1;
    got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL bypass_port0 got=%h exp=%h", got_v, exp_v); end
    got_v = rdata_a[63:32]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL bypass_port1 got=%h exp=%h", got_v, exp_v); end
    got_v = rdata_b[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL nobypass_old got=%h exp=%h", got_v, exp_v); end
    exp_q.push_back(32'hDEBBBEDD);
    tick();
    we = 1'b0;
    #1;
    got_v = rdata_b[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL merge_stored got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_zero_reg;
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wbe = 4'hF; raddr = {5'd5, 5'd0};
    exp_q.push_back('0);
    #1;
    got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL zero_bypass got=%h exp=%h", got_v, exp_v); end
    tick();
    we = 1'b0; issue_valid = 1'b1; issue_addr = 5'd0;
    exp_q.push_back('0);
    #1;
    got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL zero_stored got=%h exp=%h", got_v, exp_v); end
    tick();
    issue_valid = 1'b0;
    exp_q.push_back('0);
    #1;
    got_v = pv_a; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL zero_pending got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_scoreboard;
    issue_valid = 1'b1; issue_addr = 5'd7; raddr = {5'd5, 5'd7};
    exp_q.push_back('0);
    #1;
    got_v = W'(rp_a[0]); exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL issue_latency got=%h exp=%h", got_v, exp_v); end
    tick();
    issue_valid = 1'b0;
    exp_q.push_back(32'h80); exp_q.push_back(32'd1); exp_q.push_back('0);
    #1;
    got_v = pv_a; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL issue_set got=%h exp=%h", got_v, exp_v); end
    got_v = W'(rp_a[0]); exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL rdpend_set got=%h exp=%h", got_v, exp_v); end
    got_v = W'(rp_a[1]); exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL rdpend_other got=%h exp=%h", got_v, exp_v); end
    tick();
    issue_valid = 1'b1; issue_addr = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'h01020304; wbe = 4'hF;
    exp_q.push_back(32'd1); exp_q.push_back(32'h01020304);
    #1;
    got_v = W'(rp_a[0]); exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL rdpend_no_bypass got=%h exp=%h", got_v, exp_v); end
    got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL wb_bypass got=%h exp=%h", got_v, exp_v); end
    tick();
    issue_valid = 1'b0; we = 1'b1; waddr = 5'd7; wdata = 32'hFFFFFFFF; wbe = 4'h0;
    exp_q.push_back(32'h80);
    #1;
    got_v = pv_a; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL set_wins got=%h exp=%h", got_v, exp_v); end
    tick();
    we = 1'b0;
    exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back(32'h01020304);
    #1;
    got_v = pv_a; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL wb_clear got=%h exp=%h", got_v, exp_v); end
    got_v = W'(rp_a[0]); exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL rdpend_clear got=%h exp=%h", got_v, exp_v); end
    got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL wbe0_keeps_data got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]   nb;
    logic [W-1:0] nd, m;
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = AW'(10 + i); wdata = $urandom; wbe = 4'hF;
      vals[i] = wdata;
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr = {AW'(10 + i), AW'(10 + i)};
      exp_q.push_back(vals[i]); exp_q.push_back(vals[i]);
      #1;
      got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL b2b_full_p0[%0d] got=%h exp=%h", i, got_v, exp_v); end
      got_v = rdata_a[63:32]; exp_v = exp_q.pop_front(); n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL b2b_full_p1[%0d] got=%h exp=%h", i, got_v, exp_v); end
    end
    for (int i = 0; i < 8; i++) begin
      nb = 4'($urandom_range(0, 15));
      nd = $urandom;
      m  = vals[i];
      for (int k = 0; k < 4; k++)
        if (nb[k]) m[8*k +: 8] = nd[8*k +: 8];
      we = 1'b1; waddr = AW'(10 + i); wdata = nd; wbe = nb; raddr = {5'd0, AW'(10 + i)};
      exp_q.push_back(m); exp_q.push_back(vals[i]);
      vals[i] = m;
      #1;
      got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL b2b_bypass[%0d] got=%h exp=%h", i, got_v, exp_v); end
      got_v = rdata_b[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL b2b_old[%0d] got=%h exp=%h", i, got_v, exp_v); end
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr = {AW'(10 + i), 5'd0};
      exp_q.push_back(vals[i]);
      #1;
      got_v = rdata_b[63:32]; exp_v = exp_q.pop_front(); n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL b2b_stored[%0d] got=%h exp=%h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_clr_mid;
    we = 1'b1; waddr = 5'd3; wdata = 32'h12345678; wbe = 4'hF;
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    we = 1'b0; issue_valid = 1'b0; raddr = {5'd9, 5'd3};
    exp_q.push_back(32'h12345678); exp_q.push_back(32'h200);
    #1;
    got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL pre_clr_data got=%h exp=%h", got_v, exp_v); end
    got_v = pv_a; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL pre_clr_pv got=%h exp=%h", got_v, exp_v); end
    #2;
    clr = 1'b1;
    exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0);
    #1;
    got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL async_clr_data got=%h exp=%h", got_v, exp_v); end
    got_v = pv_a; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL async_clr_pv got=%h exp=%h", got_v, exp_v); end
    got_v = W'(rp_a[1]); exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL async_clr_rdpend got=%h exp=%h", got_v, exp_v); end
    we = 1'b1; waddr = 5'd3; wdata = 32'hFFFFFFFF; wbe = 4'hF;
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    clr = 1'b0; we = 1'b0; issue_valid = 1'b0;
    exp_q.push_back('0); exp_q.push_back('0);
    #1;
    got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL clr_discard_data got=%h exp=%h", got_v, exp_v); end
    got_v = pv_a; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL clr_discard_pv got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_depth24;
    we = 1'b1; waddr = 5'd30; wdata = 32'h55AA55AA; wbe = 4'hF;
    issue_valid = 1'b1; issue_addr = 5'd30; raddr = {5'd0, 5'd30};
    exp_q.push_back('0); exp_q.push_back(32'h55AA55AA);
    #1;
    got_v = rdata_c[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL d24_bypass got=%h exp=%h", got_v, exp_v); end
    got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL d32_bypass30 got=%h exp=%h", got_v, exp_v); end
    tick();
    we = 1'b0; issue_valid = 1'b0;
    exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0);
    exp_q.push_back(32'h40000000); exp_q.push_back(32'h55AA55AA);
    #1;
    got_v = rdata_c[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL d24_read30 got=%h exp=%h", got_v, exp_v); end
    got_v = W'(pv_c); exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL d24_pv got=%h exp=%h", got_v, exp_v); end
    got_v = W'(rp_c[0]); exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL d24_rdpend got=%h exp=%h", got_v, exp_v); end
    got_v = pv_a; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL d32_pv30 got=%h exp=%h", got_v, exp_v); end
    got_v = rdata_a[31:0]; exp_v = exp_q.pop_front(); n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL d32_read30 got=%h exp=%h", got_v, exp_v); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_merge();
    test_zero_reg();
    test_scoreboard();
    test_back_to_back();
    test_clr_mid();
    test_depth24();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
